// File: rtl/bsg_fifo_1r1w_small_monitor.sv
// rtl/bsg_fifo_1r1w_small_monitor.sv - shadow-model protocol monitor for bsg_fifo_1r1w_small
// Optional shadow data store and DATA_MISMATCH check enabled by BSG_FIFO_MON_DATA_CHECK_EN.
module bsg_fifo_1r1w_small_monitor #(
  parameter  int width_p       = 8,
  parameter  int els_p         = 4,
  parameter  int cycle_width_p = 32,
  localparam int cnt_w         = $clog2(els_p + 1),
  localparam int ptr_w         = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     enq_v_i,
  input  logic                     enq_ready_i,
  input  logic [width_p-1:0]       enq_data_i,
  input  logic                     deq_v_i,
  input  logic                     deq_yumi_i,
  input  logic [width_p-1:0]       deq_data_i,
  output logic [cnt_w-1:0]         count_o,
  output logic                     err_o,
  output logic [4:0]               err_code_o,
  output logic [4:0]               first_err_code_o,
  output logic [cycle_width_p-1:0] first_err_cycle_o
);

  logic [cnt_w-1:0]         count_q, count_d;
  logic [ptr_w-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]               err_code_q, err_code_d;
  logic [4:0]               first_code_q, first_code_d;
  logic                     err_q, err_d;
  logic [cycle_width_p-1:0] cycle_q, cycle_d;
  logic [cycle_width_p-1:0] first_cycle_q, first_cycle_d;

  logic             enq, deq, full_m, empty_m;
  logic             enq_eff, deq_eff, data_err;
  logic [4:0]       chk;
  logic [cnt_w:0]   count_sum;

  assign enq     = enq_v_i & enq_ready_i;
  assign deq     = deq_yumi_i;
  assign full_m  = (count_q == cnt_w'(els_p));
  assign empty_m = (count_q == '0);

  // A dequeue from an empty model is dropped; an enqueue into a full model
  // lands only when a real dequeue frees the slot in the same cycle.
  assign deq_eff = deq & ~empty_m;
  assign enq_eff = enq & (~full_m | deq_eff);

`ifdef BSG_FIFO_MON_DATA_CHECK_EN
  logic [width_p-1:0] shadow_q [els_p];

  always_ff @(posedge clk_i) begin
    if (enq_eff) shadow_q[wptr_q] <= enq_data_i;
  end

  assign data_err = deq & ~empty_m & (deq_data_i != shadow_q[rptr_q]);
`else
  logic unused_data;
  assign unused_data = ^{enq_data_i, deq_data_i};
  assign data_err    = 1'b0;
`endif

  assign chk[0] = enq & full_m & ~deq;
  assign chk[1] = deq & (empty_m | ~deq_v_i);
  assign chk[2] = (enq_ready_i != ~full_m);
  assign chk[3] = (deq_v_i != ~empty_m);
  assign chk[4] = data_err;

  always_comb begin
    count_sum = {1'b0, count_q} + (cnt_w + 1)'(enq_eff) - (cnt_w + 1)'(deq_eff);
    count_d   = count_sum[cnt_w-1:0];

    wptr_d = wptr_q;
    if (enq_eff) wptr_d = (wptr_q == ptr_w'(els_p - 1)) ? '0 : wptr_q + 1'b1;

    rptr_d = rptr_q;
    if (deq_eff) rptr_d = (rptr_q == ptr_w'(els_p - 1)) ? '0 : rptr_q + 1'b1;

    cycle_d = cycle_q;
    if (cycle_q != '1) cycle_d = cycle_q + 1'b1;

    err_code_d = err_code_q | chk;
    err_d      = |err_code_d;

    // Sticky code still zero means no failure has been captured yet.
    first_code_d  = first_code_q;
    first_cycle_d = first_cycle_q;
    if ((err_code_q == '0) && (chk != '0)) begin
      first_code_d  = chk;
      first_cycle_d = cycle_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cycle_q       <= '0;
      err_code_q    <= '0;
      err_q         <= 1'b0;
      first_code_q  <= '0;
      first_cycle_q <= '0;
    end else begin
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cycle_q       <= cycle_d;
      err_code_q    <= err_code_d;
      err_q         <= err_d;
      first_code_q  <= first_code_d;
      first_cycle_q <= first_cycle_d;
    end
  end

  assign count_o           = count_q;
  assign err_o             = err_q;
  assign err_code_o        = err_code_q;
  assign first_err_code_o  = first_code_q;
  assign first_err_cycle_o = first_cycle_q;

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_monitor.sv
// tb/tb_bsg_fifo_1r1w_small_monitor.sv - table-driven bench for the FIFO monitor (els_p 4 and 3)
module tb_bsg_fifo_1r1w_small_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ev, er, dv, dy;
  logic [7:0] ed, dd;

  logic [2:0]  c4;
  logic        err4;
  logic [4:0]  code4, fcode4;
  logic [31:0] fcyc4;
  logic [1:0]  c3;
  logic        err3;
  logic [4:0]  code3, fcode3;
  logic [31:0] fcyc3;

  always #5 clk = ~clk;

  bsg_fifo_1r1w_small_monitor #(.width_p(8), .els_p(4), .cycle_width_p(32)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n),
    .enq_v_i(ev), .enq_ready_i(er), .enq_data_i(ed),
    .deq_v_i(dv), .deq_yumi_i(dy), .deq_data_i(dd),
    .count_o(c4), .err_o(err4), .err_code_o(code4),
    .first_err_code_o(fcode4), .first_err_cycle_o(fcyc4)
  );

  bsg_fifo_1r1w_small_monitor #(.width_p(8), .els_p(3), .cycle_width_p(32)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n),
    .enq_v_i(ev), .enq_ready_i(er), .enq_data_i(ed),
    .deq_v_i(dv), .deq_yumi_i(dy), .deq_data_i(dd),
    .count_o(c3), .err_o(err3), .err_code_o(code3),
    .first_err_code_o(fcode3), .first_err_cycle_o(fcyc3)
  );

`ifdef BSG_FIFO_MON_DATA_CHECK_EN
  localparam logic [4:0] DM_CODE = 5'b10000;
`else
  localparam logic [4:0] DM_CODE = 5'b00000;
`endif

  typedef struct {
    logic       ev, er, dv, dy;
    logic [7:0] ed, dd;
    logic [2:0] cnt;
    logic [4:0] code;
  } vec_t;

  typedef struct {
    int         sel;
    logic [2:0] cnt;
    logic [4:0] code;
    string      tag;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   sel_g = 0;
  int   passed = 0;
  int   total = 0;

  function automatic vec_t mk(input logic e_v, e_r, input logic [7:0] e_d,
                              input logic d_v, d_y, input logic [7:0] d_d,
                              input logic [2:0] cnt, input logic [4:0] code);
    vec_t v;
    v.ev = e_v; v.er = e_r; v.ed = e_d;
    v.dv = d_v; v.dy = d_y; v.dd = d_d;
    v.cnt = cnt; v.code = code;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_idle();
    ev = 1'b0; er = 1'b0; ed = 8'h00;
    dv = 1'b0; dy = 1'b0; dd = 8'h00;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    exp_t e;
    ev = v.ev; er = v.er; ed = v.ed;
    dv = v.dv; dy = v.dy; dd = v.dd;
    sb.push_back('{sel_g, v.cnt, v.code, tag, idx});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel == 0) begin
      check($sformatf("%s[%0d].count", e.tag, e.idx), 32'(c4), 32'(e.cnt));
      check($sformatf("%s[%0d].code", e.tag, e.idx), 32'(code4), 32'(e.code));
    end else begin
      check($sformatf("%s[%0d].count", e.tag, e.idx), 32'(c3), 32'(e.cnt));
      check($sformatf("%s[%0d].code", e.tag, e.idx), 32'(code3), 32'(e.code));
    end
    @(negedge clk);
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tag, i);
    tbl.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_fill4();
    tbl.push_back(mk(1, 1, 8'h11, 0, 0, 8'h00, 3'd1, 5'b0));
    tbl.push_back(mk(1, 1, 8'h22, 1, 0, 8'h00, 3'd2, 5'b0));
    tbl.push_back(mk(1, 1, 8'h33, 1, 0, 8'h00, 3'd3, 5'b0));
    tbl.push_back(mk(1, 1, 8'h44, 1, 0, 8'h00, 3'd4, 5'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    #2;
    check("reset.count4", 32'(c4), 32'd0);
    check("reset.err4", 32'(err4), 32'd0);
    check("reset.code4", 32'(code4), 32'd0);
    check("reset.fcode4", 32'(fcode4), 32'd0);
    check("reset.fcyc4", fcyc4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sel_g = 0;
    push_fill4();
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h11, 3'd3, 5'b0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h22, 3'd2, 5'b0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h33, 3'd1, 5'b0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h44, 3'd0, 5'b0));
    run("filldrain");
    check("filldrain.err", 32'(err4), 32'd0);

    do_reset();
    push_fill4();
    for (int i = 4; i < 20; i++) tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd4, 5'b0));
    tbl.push_back(mk(1, 1, 8'h55, 1, 0, 8'h00, 3'd4, 5'b00101));
    run("overflow");
    check("overflow.err", 32'(err4), 32'd1);
    check("overflow.fcode", 32'(fcode4), 32'b00101);
    check("overflow.fcyc", fcyc4, 32'd20);

    do_reset();
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 3'd0, 5'b0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h00, 3'd0, 5'b00010));
    run("underflow");
    check("underflow.fcode", 32'(fcode4), 32'b00010);
    check("underflow.fcyc", fcyc4, 32'd3);

    do_reset();
    tbl.push_back(mk(1, 1, 8'hA5, 0, 0, 8'h00, 3'd1, 5'b0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'hA4, 3'd0, DM_CODE));
    run("datamismatch");
    check("datamismatch.err", 32'(err4), 32'(|DM_CODE));

    do_reset();
    sel_g = 1;
    tbl.push_back(mk(1, 1, 8'd0, 0, 0, 8'd0, 3'd1, 5'b0));
    tbl.push_back(mk(1, 1, 8'd1, 1, 0, 8'd0, 3'd2, 5'b0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, 1, 8'(k + 2), 1, 1, 8'(k), 3'd2, 5'b0));
    tbl.push_back(mk(0, 1, 8'd0, 0, 1, 8'd10, 3'd1, 5'b01010));
    tbl.push_back(mk(1, 0, 8'd0, 1, 0, 8'd0, 3'd1, 5'b01110));
    run("wrap");
    check("wrap.fcode", 32'(fcode3), 32'b01010);
    check("wrap.fcyc", fcyc3, 32'd12);
    check("wrap.err", 32'(err3), 32'd1);

    do_reset();
    sel_g = 0;
    tbl.push_back(mk(1, 1, 8'h11, 0, 0, 8'h00, 3'd1, 5'b0));
    tbl.push_back(mk(1, 1, 8'h22, 1, 0, 8'h00, 3'd2, 5'b0));
    tbl.push_back(mk(1, 1, 8'h33, 1, 0, 8'h00, 3'd3, 5'b0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd3, 5'b00100));
    run("midpre");
    check("midpre.err", 32'(err4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.count", 32'(c4), 32'd0);
    check("midrst.err", 32'(err4), 32'd0);
    check("midrst.code", 32'(code4), 32'd0);
    check("midrst.fcode", 32'(fcode4), 32'd0);
    check("midrst.fcyc", fcyc4, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tbl.push_back(mk(1, 1, 8'h55, 0, 0, 8'h00, 3'd1, 5'b0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h55, 3'd0, 5'b0));
    run("midpost");
    check("midpost.err", 32'(err4), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
